fpr_cdb_arbiter: RTL and testbench
==================================

# fpr_cdb_arbiter

Schedules access to the floating-point register common data bus (FPR CDB) among fixed-latency FP execution units (fadd/fsub, fmul, fdiv/fsqrt, move/neg). Each requester is granted a future broadcast slot at its pipeline latency. A reservation ring guarantees that no two results reach the CDB in the same cycle. The block also drives the CDB itself: it muxes the tag and the result data of the unit whose slot is due.

## Interface
Parameters:
- N_REQ, 4, number of requesting units
- MAX_LAT, 16, reservation ring depth; legal request latency is 1..MAX_LAT-1
- LAT_WIDTH, $clog2(MAX_LAT), latency field width

Ports:
- clk  input  1  clock; single clock domain
- reset  input  1  synchronous, active-high; clears all reservations
- req_valid[N_REQ]  input  1  unit i wants a slot this cycle
- req_lat[N_REQ]  input  LAT_WIDTH  cycles from grant to result-valid for unit i (fdiv vs fsqrt differ)
- req_tag[N_REQ]  input  ROB_WIDTH  ROB tag of the instruction being dispatched
- req_ready[N_REQ]  output  1  grant; the unit dispatches when valid&&ready
- result[N_REQ]  input  32  unit i result bus, sampled only when its slot is due
- fpr_cdb  output  cdb_t  {valid, tag, data} broadcast
- cdb_src  output  N_REQ  one-hot source of the current broadcast, all-zero when idle

## Operation
- Ring entry slot[k] holds {busy, src index, tag}. slot[k].busy means a broadcast occurs k cycles from now.
- Each cycle, every entry shifts down: slot[k] <= slot[k+1]. slot[MAX_LAT-1] refills with idle.
- Request i is grantable when req_valid[i] is high, slot[req_lat[i]].busy is low (pre-shift index, i.e. the entry that becomes slot[req_lat[i]-1]), and no higher-priority request this cycle targets the same latency.
- Multiple grants per cycle are allowed when the latencies differ. At most one grant per latency value per cycle.
- A grant writes {busy=1, src=i, tag=req_tag[i]} into post-shift slot[req_lat[i]-1].
- Broadcast is combinational from slot[0]:
  - fpr_cdb.valid = slot[0].busy
  - fpr_cdb.tag = slot[0].tag
  - fpr_cdb.data = result[slot[0].src]
  - cdb_src = onehot(slot[0].src)
- When idle: tag and data are don't-care, cdb_src = 0.
- req_ready depends on req_valid, req_lat and ring state. A unit must not make req_valid depend on req_ready. A unit may withdraw an ungranted request.
- req_lat=0 or req_lat>=MAX_LAT is illegal. The request is never granted and is flagged by an assertion.

## Timing
- Grant in cycle t with latency L: fpr_cdb.valid is high in cycle t+L exactly, for one cycle.
- A request whose slot is free is granted in the same cycle, with zero arbitration bubbles.
- Reset values: every slot idle; fpr_cdb.valid=0; cdb_src=0; req_ready=0 for all units during the reset cycle.
- The round-robin pointer resets to 0.
- Reset mid-operation: all reservations are dropped. No broadcast occurs in the cycle after reset, even for slots already granted. Units must discard their in-flight results on reset.
- Ring full (all slots busy): all req_ready=0. No stall is propagated beyond that.
- Simultaneous grant and slot expiry: slot[0] broadcasts, and the new reservation lands at slot[L-1]. The ring shifts before insertion, so the two never collide.

## Configuration
- FPR_CDB_ARB_RR_EN defined:
  - Same-latency conflicts are resolved round-robin.
  - The pointer advances to (winner+1) mod N_REQ whenever a conflict is resolved.
- FPR_CDB_ARB_RR_EN undefined:
  - Fixed priority, lower index wins.
  - No pointer register.

## Structure
- Shared package / common.vh: cdb_t (already present), ROB_WIDTH, FPR_CDB_MAX_LAT, and per-unit latency constants (FADD_LAT, FMUL_LAT, FDIV_LAT, FSQRT_LAT).
- The slot entry struct cdb_slot_t is local to the block.
- One sub-module, cdb_slot_ring: shift register plus insert ports; reports busy per latency.
- Arbitration and the data mux stay in fpr_cdb_arbiter.

## Test plan
- Single request: unit 1, L=3, tag 5 in cycle 10. Expect fpr_cdb.valid only in cycle 13, tag=5, data=result[1], cdb_src=4'b0010.
- Different latencies: units 0 (L=2) and 2 (L=5) request together in cycle 0. Both are granted. Expect broadcasts in cycles 2 and 5.
- Same-latency conflict: units 0 and 3, both L=4, held valid for 4 cycles.
  - Without RR: unit 0 is granted every cycle.
  - With RR: grants alternate 0,3,0,3.
- Slot collision: unit 1 granted L=6 in cycle 0; unit 2 requests L=4 in cycle 2 (target cycle 6). Expect req_ready[2]=0 in cycle 2 and a grant in cycle 3 (broadcast in cycle 7).
- Reset mid-flight: grants with L=5 in cycles 0–2, reset in cycle 3. Expect no fpr_cdb.valid in cycles 4–7 and req_ready=0 in cycle 3.
- Full ring: MAX_LAT-1 back-to-back L=1..15 grants, then a further request. Expect that request to be denied until the target slot frees, with no duplicate broadcasts.

Source files
------------

// File: rtl/fpr_cdb_arbiter_pkg.sv
// Shared FP CDB definitions: broadcast struct, ROB tag width, ring depth,
// per-unit pipeline latencies and the round-robin rank helper.
package fpr_cdb_arbiter_pkg;

  localparam int ROB_WIDTH       = 6;
  localparam int FPR_CDB_MAX_LAT = 16;

  localparam int FADD_LAT  = 3;
  localparam int FMUL_LAT  = 4;
  localparam int FDIV_LAT  = 12;
  localparam int FSQRT_LAT = 15;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  // Position of requester idx in the rotation that starts at ptr (0 = highest priority).
  function automatic int rr_rank(input int idx, input int ptr, input int n);
    return (idx >= ptr) ? (idx - ptr) : (idx + n - ptr);
  endfunction

endpackage

// File: rtl/cdb_slot_ring.sv
// Reservation ring for the FP CDB. Entry k describes the broadcast due k
// cycles from now; the MSB of every entry is its busy flag. Each cycle the
// ring shifts toward entry 0, the top refills idle, and granted requests are
// written into the post-shift positions. Callers guarantee distinct indices.
module cdb_slot_ring
  import fpr_cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = FPR_CDB_MAX_LAT,
  parameter int N_INS = 4,
  parameter int W     = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_INS-1:0]            i_ins_valid,
  input  logic [N_INS-1:0][IDX_W-1:0] i_ins_idx,
  input  logic [N_INS-1:0][W-1:0]     i_ins_entry,
  output logic [DEPTH-1:0]            o_busy,
  output logic [W-1:0]                o_head
);

  logic [W-1:0] r_slot      [DEPTH];
  logic [W-1:0] w_slot_next [DEPTH];

  // Shift down one place, refill the top with idle, then drop in this cycle's grants.
  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) begin
      w_slot_next[k] = r_slot[k+1];
    end
    w_slot_next[DEPTH-1] = '0;
    for (int p = 0; p < N_INS; p++) begin
      if (i_ins_valid[p]) begin
        w_slot_next[i_ins_idx[p]] = i_ins_entry[p];
      end
    end
  end

  // Ring state; reset drops every reservation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        r_slot[k] <= w_slot_next[k];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign o_busy[gi] = r_slot[gi][W-1];
    end
  endgenerate

  assign o_head = r_slot[0];

endmodule

// File: rtl/fpr_cdb_arbiter.sv
// FP register CDB arbiter. Each unit requests a broadcast slot at its own
// pipeline latency; a grant reserves the ring entry that reaches the head
// exactly L cycles later. Several grants per cycle are fine as long as their
// latencies differ. The CDB is driven directly from the ring head.
// Optional feature macro: FPR_CDB_ARB_RR_EN selects round-robin resolution of
// same-latency conflicts; without it the lower index wins.
module fpr_cdb_arbiter
  import fpr_cdb_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_LAT   = FPR_CDB_MAX_LAT,
  parameter int LAT_WIDTH = $clog2(MAX_LAT)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0][LAT_WIDTH-1:0]     req_lat,
  input  logic [N_REQ-1:0][ROB_WIDTH-1:0]     req_tag,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0][31:0]              result,
  output cdb_t                                fpr_cdb,
  output logic [N_REQ-1:0]                    cdb_src
);

  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic                 busy;
    logic [SRC_W-1:0]     src;
    logic [ROB_WIDTH-1:0] tag;
  } cdb_slot_t;

  logic [MAX_LAT-1:0]              w_busy;
  cdb_slot_t                       w_head;
  logic [N_REQ-1:0]                w_lat_ok;
  logic [N_REQ-1:0]                w_cand;
  logic [N_REQ-1:0]                w_grant;
  logic [N_REQ-1:0][LAT_WIDTH-1:0] w_ins_idx;
  cdb_slot_t [N_REQ-1:0]           w_ins_entry;

`ifdef FPR_CDB_ARB_RR_EN
  logic [SRC_W-1:0] r_rr_ptr;
  logic [SRC_W-1:0] w_rr_ptr_next;
  logic [N_REQ-1:0] w_contested;
`endif

  // A request is a candidate when its latency is legal and its target slot is still free.
  // The grant lands at post-shift index L-1, which is pre-shift index L.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_lat_ok[gi]    = (req_lat[gi] != '0) && (int'(req_lat[gi]) < MAX_LAT);
      assign w_cand[gi]      = req_valid[gi] && w_lat_ok[gi] && !w_busy[req_lat[gi]];
      assign w_ins_idx[gi]   = req_lat[gi] - LAT_WIDTH'(1);
      assign w_ins_entry[gi] = '{busy: 1'b1, src: SRC_W'(gi), tag: req_tag[gi]};
    end
  endgenerate

  // Grant each candidate unless a higher-priority candidate targets the same latency.
  always_comb begin
    w_grant = '0;
`ifdef FPR_CDB_ARB_RR_EN
    w_contested = '0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      w_grant[i] = w_cand[i];
      for (int j = 0; j < N_REQ; j++) begin
        if (j != i && w_cand[j] && req_lat[j] == req_lat[i]) begin
`ifdef FPR_CDB_ARB_RR_EN
          w_contested[i] = 1'b1;
          if (rr_rank(j, int'(r_rr_ptr), N_REQ) < rr_rank(i, int'(r_rr_ptr), N_REQ)) begin
            w_grant[i] = 1'b0;
          end
`else
          if (j < i) begin
            w_grant[i] = 1'b0;
          end
`endif
        end
      end
    end
  end

`ifdef FPR_CDB_ARB_RR_EN
  // The contested winner closest to the pointer moves the pointer just past itself.
  always_comb begin
    int   idx;
    logic found;
    w_rr_ptr_next = r_rr_ptr;
    found         = 1'b0;
    idx           = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!found && w_grant[idx] && w_contested[idx]) begin
        found         = 1'b1;
        w_rr_ptr_next = SRC_W'((idx + 1) % N_REQ);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_ptr_next;
    end
  end
`endif

  cdb_slot_ring #(
    .DEPTH (MAX_LAT),
    .N_INS (N_REQ),
    .W     ($bits(cdb_slot_t)),
    .IDX_W (LAT_WIDTH)
  ) u_ring (
    .clk         (clk),
    .reset       (reset),
    .i_ins_valid (w_grant),
    .i_ins_idx   (w_ins_idx),
    .i_ins_entry (w_ins_entry),
    .o_busy      (w_busy),
    .o_head      (w_head)
  );

  assign req_ready = reset ? '0 : w_grant;

  // Drive the CDB straight from the ring head; muted while reset is held.
  always_comb begin
    fpr_cdb.valid = w_head.busy && !reset;
    fpr_cdb.tag   = w_head.tag;
    fpr_cdb.data  = result[w_head.src];
    cdb_src       = '0;
    if (fpr_cdb.valid) begin
      cdb_src[w_head.src] = 1'b1;
    end
  end

  // A unit asking with latency 0 or >= MAX_LAT is a dispatch bug; it is never granted.
  a_legal_lat: assert property (@(posedge clk) disable iff (reset)
                                ((req_valid & ~w_lat_ok) == '0));

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Bench for fpr_cdb_arbiter: table vectors on a fresh ring, hand-written
// multi-cycle sequences, and randomized traffic, all cross-checked every cycle
// against a booking model keyed by absolute cycle number.
module tb_fpr_cdb_arbiter;
  import fpr_cdb_arbiter_pkg::*;

  logic                        clk;
  logic                        reset;
  logic [3:0]                  req_valid;
  logic [3:0][3:0]             req_lat;
  logic [3:0][ROB_WIDTH-1:0]   req_tag;
  logic [3:0]                  req_ready;
  logic [3:0][31:0]            result;
  cdb_t                        fpr_cdb;
  logic [3:0]                  cdb_src;

  fpr_cdb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_lat   (req_lat),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .result    (result),
    .fpr_cdb   (fpr_cdb),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     bk_src [longint];
  int     bk_tag [longint];
  int     m_ptr  = 0;

  localparam logic [23:0] TAGS = {6'd12, 6'd9, 6'd5, 6'd7};

  typedef struct packed {
    logic [3:0]  v;
    logic [15:0] lat;
    logic [3:0]  ready;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the booking model, commit.
  task automatic tick(input logic rst, input logic [3:0] v, input logic [15:0] lat,
                      input logic [23:0] tag);
    logic [3:0]           e_ready;
    logic                 e_valid;
    logic [ROB_WIDTH-1:0] e_tag;
    logic [31:0]          e_data;
    logic [3:0]           e_src;
    int                   conf_win;
    int                   conf_rank;
    @(negedge clk);
    reset     = rst;
    req_valid = v;
    req_lat   = lat;
    req_tag   = tag;
    for (int i = 0; i < 4; i++) result[i] = $urandom;
    #1;
    e_ready = '0; e_valid = 1'b0; e_tag = '0; e_data = '0; e_src = '0;
    conf_win = -1; conf_rank = 99;
    if (!rst) begin
      if (bk_src.exists(cyc)) begin
        e_valid = 1'b1;
        e_tag   = ROB_WIDTH'(bk_tag[cyc]);
        e_data  = result[bk_src[cyc]];
        e_src   = 4'(1 << bk_src[cyc]);
      end
      for (int L = 1; L < 16; L++) begin
        int n, best, best_rank, r;
        n = 0; best = -1; best_rank = 99; r = 0;
        if (!bk_src.exists(cyc + L)) begin
          for (int i = 0; i < 4; i++) begin
            if (v[i] && int'(req_lat[i]) == L) begin
              n++;
`ifdef FPR_CDB_ARB_RR_EN
              r = (i - m_ptr + 4) % 4;
`else
              r = i;
`endif
              if (r < best_rank) begin best_rank = r; best = i; end
            end
          end
          if (best >= 0) e_ready[best] = 1'b1;
          if (n > 1 && best_rank < conf_rank) begin conf_rank = best_rank; conf_win = best; end
        end
      end
    end
    chk("ready", req_ready, e_ready);
    chk("valid", fpr_cdb.valid, e_valid);
    chk("cdb_src", cdb_src, e_src);
    if (e_valid) begin
      chk("tag", fpr_cdb.tag, e_tag);
      chk("data", fpr_cdb.data, e_data);
      $display("cyc=%0d broadcast tag=%0d src=%b", cyc, fpr_cdb.tag, cdb_src);
    end
    if (rst) begin
      bk_src.delete();
      bk_tag.delete();
      m_ptr = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (e_ready[i]) begin
          bk_src[cyc + longint'(req_lat[i])] = i;
          bk_tag[cyc + longint'(req_lat[i])] = int'(tag[i*ROB_WIDTH +: ROB_WIDTH]);
        end
      end
      if (conf_win >= 0) m_ptr = (conf_win + 1) % 4;
      if (bk_src.exists(cyc)) begin
        bk_src.delete(cyc);
        bk_tag.delete(cyc);
      end
    end
    cyc++;
  endtask

  initial begin
    int vcount;
    int gcyc;
    logic granted;
    reset = 1'b1; req_valid = '0; req_lat = '0; req_tag = '0; result = '0;

    tbl[0] = '{v: 4'b0001, lat: 16'h0001, ready: 4'b0001};
    tbl[1] = '{v: 4'b1111, lat: 16'h4321, ready: 4'b1111};
    tbl[2] = '{v: 4'b1111, lat: 16'h7777, ready: 4'b0001};
    tbl[3] = '{v: 4'b0110, lat: 16'h0FF0, ready: 4'b0010};
    tbl[4] = '{v: 4'b1010, lat: 16'h10F0, ready: 4'b1010};
    tbl[5] = '{v: 4'b1100, lat: 16'h9900, ready: 4'b0100};
    tbl[6] = '{v: 4'b0000, lat: 16'h0000, ready: 4'b0000};
    tbl[7] = '{v: 4'b1011, lat: 16'h8033, ready: 4'b1001};

    // reset state
    tick(1'b1, 4'b0000, 16'h0000, TAGS);
    chk("rst_valid", fpr_cdb.valid, 1'b0);
    chk("rst_src", cdb_src, 4'b0000);

    // table vectors, each on a fresh ring, then drained
    for (int t = 0; t < 8; t++) begin
      tick(1'b1, 4'b0000, 16'h0000, TAGS);
      tick(1'b0, tbl[t].v, tbl[t].lat, 24'($urandom));
      chk("tbl_ready", req_ready, tbl[t].ready);
      $display("vector %0d v=%b lat=%h ready=%b", t, tbl[t].v, tbl[t].lat, req_ready);
      for (int c = 0; c < 16; c++) tick(1'b0, 4'b0000, 16'h0000, TAGS);
    end

    // single request: unit 1, L=3, tag 5 at relative cycle 10
    tick(1'b1, 4'b0000, 16'h0000, TAGS);
    for (int c = 0; c < 16; c++) begin
      tick(1'b0, (c == 10) ? 4'b0010 : 4'b0000, 16'h0030, TAGS);
      if (c == 10) chk("single_ready", req_ready, 4'b0010);
      chk("single_valid", fpr_cdb.valid, (c == 13));
      if (c == 13) begin
        chk("single_tag", fpr_cdb.tag, 6'd5);
        chk("single_data", fpr_cdb.data, result[1]);
        chk("single_src", cdb_src, 4'b0010);
      end
    end
    $display("sequence single done");

    // different latencies: unit 0 L=2 and unit 2 L=5 together
    tick(1'b1, 4'b0000, 16'h0000, TAGS);
    for (int c = 0; c < 7; c++) begin
      tick(1'b0, (c == 0) ? 4'b0101 : 4'b0000, 16'h0502, TAGS);
      if (c == 0) chk("difflat_ready", req_ready, 4'b0101);
      chk("difflat_valid", fpr_cdb.valid, (c == 2 || c == 5));
      if (c == 2) chk("difflat_src2", cdb_src, 4'b0001);
      if (c == 5) chk("difflat_src5", cdb_src, 4'b0100);
    end
    $display("sequence different-latency done");

    // same-latency conflict: units 0 and 3, both L=4, four cycles
    tick(1'b1, 4'b0000, 16'h0000, TAGS);
    for (int c = 0; c < 9; c++) begin
      tick(1'b0, (c < 4) ? 4'b1001 : 4'b0000, 16'h4004, TAGS);
`ifdef FPR_CDB_ARB_RR_EN
      if (c < 4) chk("conflict_ready", req_ready, (c % 2 == 0) ? 4'b0001 : 4'b1000);
      if (c >= 4 && c < 8) chk("conflict_src", cdb_src, (c % 2 == 0) ? 4'b0001 : 4'b1000);
`else
      if (c < 4) chk("conflict_ready", req_ready, 4'b0001);
      if (c >= 4 && c < 8) chk("conflict_src", cdb_src, 4'b0001);
`endif
    end
    $display("sequence conflict done");

    // slot collision: unit 1 L=6 at 0; unit 2 L=4 from cycle 2
    tick(1'b1, 4'b0000, 16'h0000, TAGS);
    for (int c = 0; c < 9; c++) begin
      tick(1'b0, (c == 0) ? 4'b0010 : ((c == 2 || c == 3) ? 4'b0100 : 4'b0000), 16'h0460, TAGS);
      if (c == 0) chk("coll_ready0", req_ready, 4'b0010);
      if (c == 2) chk("coll_ready2", req_ready, 4'b0000);
      if (c == 3) chk("coll_ready3", req_ready, 4'b0100);
      if (c == 6) chk("coll_src6", cdb_src, 4'b0010);
      if (c == 7) chk("coll_src7", cdb_src, 4'b0100);
    end
    $display("sequence collision done");

    // reset mid-flight: unit 0 L=5 in cycles 0-2, reset in cycle 3
    tick(1'b1, 4'b0000, 16'h0000, TAGS);
    for (int c = 0; c < 8; c++) begin
      tick(c == 3, (c <= 3) ? 4'b0001 : 4'b0000, 16'h0005, TAGS);
      if (c < 3) chk("rstmid_grant", req_ready, 4'b0001);
      if (c == 3) chk("rstmid_ready", req_ready, 4'b0000);
      if (c >= 3) chk("rstmid_valid", fpr_cdb.valid, 1'b0);
    end
    $display("sequence reset-mid-flight done");

    // full ring: unit 0 L=15 for 15 cycles, then requests must wait
    tick(1'b1, 4'b0000, 16'h0000, TAGS);
    vcount = 0; gcyc = -1; granted = 1'b0;
    for (int c = 0; c < 15; c++) tick(1'b0, 4'b0001, 16'h000F, TAGS);
    tick(1'b0, 4'b1110, 16'hE710, TAGS);
    chk("full_ready", req_ready, 4'b0000);
    if (fpr_cdb.valid) vcount++;
    for (int c = 16; c < 32; c++) begin
      tick(1'b0, granted ? 4'b0000 : 4'b0010, 16'h0050, TAGS);
      if (!granted && req_ready[1]) begin granted = 1'b1; gcyc = c; end
      if (c <= 30 && fpr_cdb.valid) vcount++;
    end
    chk("full_grant_cycle", 64'(gcyc), 64'd25);
    chk("full_bcast_count", 64'(vcount), 64'd16);
    $display("sequence full-ring grant=%0d broadcasts=%0d", gcyc, vcount);

    // randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      logic [3:0]  rv;
      logic [15:0] rl;
      for (int i = 0; i < 4; i++) begin
        rl[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 4))
                                                   : 4'($urandom_range(1, 15));
      end
      rv = 4'($urandom);
      tick($urandom_range(0, 63) == 0, rv, rl, 24'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
